// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: 32x32 signed radix-2 Booth multiplier, one step per clock.
// Optional MULT_ZERO_SKIP_EN finishes immediately when either operand is zero.
module booth_mult_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_mult,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state, state_nx;
  logic [64:0] p, p_nx;
  logic [31:0] m, m_nx;
  logic [4:0]  count, count_nx;
  logic [32:0] acc, sum;
  logic        start, zero;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      p     <= '0;
      m     <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      p     <= p_nx;
      m     <= m_nx;
      count <= count_nx;
    end
  // The sum keeps a 33rd sign bit so the shift-in stays correct when M is -2^31.
  always_comb begin
    start    = ctrl_mult && state != RUN;
    acc      = {p[64], p[64:33]};
    sum      = p[1:0] == 2'b01 ? acc + {m[31], m} :
               p[1:0] == 2'b10 ? acc - {m[31], m} : acc;
`ifdef MULT_ZERO_SKIP_EN
    zero     = count == 5'd0 && (m == 32'd0 || p[32:1] == 32'd0);
`else
    zero     = 1'b0;
`endif
    state_nx = state;
    p_nx     = p;
    m_nx     = m;
    count_nx = count;
    if (start) begin
      state_nx = RUN;
      m_nx     = data_a;
      p_nx     = {32'd0, data_b, 1'b0};
      count_nx = 5'd0;
    end else if (state == RUN) begin
      p_nx     = zero ? 65'd0 : {sum, p[32:1]};
      count_nx = count + 5'd1;
      state_nx = zero || count == 5'd31 ? DONE : RUN;
    end else if (state == DONE)
      state_nx = IDLE;
  end
  assign data_result    = p[32:1];
  assign data_exception = !(&p[64:32] || ~|p[64:32]);
  assign data_resultRDY = state == DONE;
  assign busy           = state == RUN;
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: randomized and directed checks of booth_mult_ctrl against a 64-bit arithmetic model.
module tb_booth_mult_ctrl;
  logic        clk = 1'b0, reset = 1'b0, ctrl_mult = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  int          errors = 0, checks = 0;

  booth_mult_ctrl dut (
    .clk(clk), .reset(reset), .ctrl_mult(ctrl_mult), .data_a(data_a), .data_b(data_b),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic longint ref_prod(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  function automatic logic ref_exc(input logic [31:0] a, input logic [31:0] b);
    longint pr = ref_prod(a, b);
    return pr != longint'(int'(pr));
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 32;
  endfunction

  // Samples k = 0..lat cycles after the start edge; counts cycles where busy/RDY timing is off.
  task automatic wait_op(input int lat, input int pulse, input logic [31:0] pa, input logic [31:0] pb,
                         output logic [31:0] r, output logic e, output int bad);
    bad = 0;
    r = 'x;
    e = 1'bx;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy !== (k < lat) || data_resultRDY !== (k == lat)) bad++;
      if (k == lat) begin
        r = data_result;
        e = data_exception;
      end
      ctrl_mult = (k == pulse);
      if (k == pulse) begin
        data_a = pa;
        data_b = pb;
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e, output int bad);
    @(negedge clk);
    ctrl_mult = 1'b1;
    data_a = a;
    data_b = b;
    @(posedge clk);
    #1;
    ctrl_mult = 1'b0;
    wait_op(ref_lat(a, b), -1, '0, '0, r, e, bad);
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {data_result, data_exception, data_resultRDY, busy});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b rdy=%b want 0/0", busy, data_resultRDY);
    end
  endtask

  task automatic test_directed;
    logic [31:0] ta [5] = '{32'd3, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] tb [5] = '{32'd5, 32'd6, 32'd2, 32'hFFFFFFFF, 32'd1};
    logic [31:0] tr [5] = '{32'd15, 32'hFFFFFFD6, 32'hFFFFFFFE, 32'h80000000, 32'h80000000};
    logic        te [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] r;
    logic        e;
    int          bad;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], r, e, bad);
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL directed_timing[%0d] bad_cycles=%0d want 0", i, bad);
      end
      checks++;
      if (r !== tr[i]) begin
        errors++;
        $display("FAIL directed_result[%0d] got=%h want=%h", i, r, tr[i]);
      end
      checks++;
      if (e !== te[i]) begin
        errors++;
        $display("FAIL directed_exception[%0d] got=%b want=%b", i, e, te[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, r;
    logic        e;
    int          bad;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 300) - 150; b = $urandom_range(0, 300) - 150; end
        2: begin a = $urandom_range(0, 1) ? 32'h80000000 : 32'h7FFFFFFF; b = $urandom; end
        default: begin a = $urandom & 32'h0000FFFF; b = $urandom_range(0, 1) ? 32'd0 : 32'hFFFFFFFF; end
      endcase
      run_op(a, b, r, e, bad);
      checks++;
      if (bad !== 0 || r !== 32'(ref_prod(a, b)) || e !== ref_exc(a, b)) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h got r=%h e=%b bad=%0d want r=%h e=%b",
                 i, a, b, r, e, bad, 32'(ref_prod(a, b)), ref_exc(a, b));
      end
      @(posedge clk);
      #1;
      checks++;
      if (data_result !== r || data_exception !== e || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL random_hold[%0d] got r=%h e=%b rdy=%b busy=%b want r=%h e=%b rdy=0 busy=0",
                 i, data_result, data_exception, data_resultRDY, busy, r, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic        e;
    int          bad;
    @(negedge clk);
    ctrl_mult = 1'b1;
    data_a = 32'd4;
    data_b = 32'd4;
    @(posedge clk);
    #1;
    ctrl_mult = 1'b0;
    wait_op(32, 9, 32'd9, 32'd9, r, e, bad);
    checks++;
    if (bad !== 0 || r !== 32'd16 || e !== 1'b0) begin
      errors++;
      $display("FAIL ignore_in_run got r=%h e=%b bad=%0d want r=00000010 e=0 bad=0", r, e, bad);
    end
    ctrl_mult = 1'b1;
    data_a = 32'd2;
    data_b = 32'd3;
    @(posedge clk);
    #1;
    ctrl_mult = 1'b0;
    wait_op(32, -1, '0, '0, r, e, bad);
    checks++;
    if (bad !== 0 || r !== 32'd6 || e !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got r=%h e=%b bad=%0d want r=00000006 e=0 bad=0", r, e, bad);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a, b, r;
    logic        e;
    int          bad, rdy_seen;
    a = $urandom | 32'd1;
    b = $urandom | 32'd1;
    @(negedge clk);
    ctrl_mult = 1'b1;
    data_a = a;
    data_b = b;
    @(posedge clk);
    #1;
    ctrl_mult = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%h want=0", {data_result, data_exception, data_resultRDY, busy});
    end
    @(negedge clk);
    reset = 1'b1;
    rdy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) rdy_seen++;
    end
    checks++;
    if (rdy_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_rdy active_cycles=%0d want 0", rdy_seen);
    end
    run_op(b, a, r, e, bad);
    checks++;
    if (bad !== 0 || r !== 32'(ref_prod(b, a)) || e !== ref_exc(b, a)) begin
      errors++;
      $display("FAIL after_reset_op got r=%h e=%b bad=%0d want r=%h e=%b bad=0",
               r, e, bad, 32'(ref_prod(b, a)), ref_exc(b, a));
    end
  endtask

  task automatic test_zero;
    logic [31:0] r;
    logic        e;
    int          bad;
    run_op(32'd0, 32'd123, r, e, bad);
    checks++;
    if (bad !== 0 || r !== 32'd0 || e !== 1'b0) begin
      errors++;
      $display("FAIL zero_a got r=%h e=%b bad=%0d want r=0 e=0 bad=0 lat=%0d", r, e, bad, ref_lat(32'd0, 32'd123));
    end
    run_op(32'hFFFFFFFF, 32'd0, r, e, bad);
    checks++;
    if (bad !== 0 || r !== 32'd0 || e !== 1'b0) begin
      errors++;
      $display("FAIL zero_b got r=%h e=%b bad=%0d want r=0 e=0 bad=0", r, e, bad);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_zero;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
